uart_rx: RTL and testbench

UART receive stage that consumes the serial `rx` line driven into `top` by the host and presents each 8N1 byte to downstream logic. It synchronises the asynchronous line, detects and qualifies start bits, samples each bit at its centre, checks the stop bit, and holds the result in a valid/ready output register. The default baud matches the system rate of 115200 at 50 MHz, a bit period of 8680 ns.

---
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a valid/ready output register.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   rx         asynchronous serial line, idle high, LSB first
//   data       last received byte
//   valid      data holds an unconsumed byte
//   ready      consumer accepts data when valid && ready
//   frame_err  one-cycle pulse, stop bit sampled low
//   overrun    one-cycle pulse, a new byte replaced an unconsumed one
//   busy       high while a frame is being received
//
// state     | meaning
// WAIT_HIGH | line must read high before a start bit is accepted
// IDLE      | waiting for a falling edge on the synchronised line
// START     | counting to the start-bit centre, rejecting glitches
// DATA      | sampling eight data bits at their centres
// STOP      | sampling the stop bit, then load or flag framing error

module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF         = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_WAIT_HIGH,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic            s1_q;
  logic            rx_s_q;
  logic            busy_q;
  logic            load_q;
  logic            ferr_q;

  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;
  logic            pop;

  // Receive FSM. load_q / ferr_q are single-cycle strobes raised at the
  // stop-bit sample; the output register acts on them one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WAIT_HIGH;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      s1_q    <= 1'b1;
      rx_s_q  <= 1'b1;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      s1_q   <= rx;
      rx_s_q <= s1_q;
      load_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        S_WAIT_HIGH: begin
          if (rx_s_q) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == CW'(HALF - 1)) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              state_q <= S_DATA;
              idx_q   <= '0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            shift_q[idx_q] <= rx_s_q;
            cnt_q          <= '0;
            if (idx_q == 3'd7) state_q <= S_STOP;
            else               idx_q   <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            // Returning at the stop-bit centre re-arms half a bit early.
            if (rx_s_q) begin
              state_q <= S_IDLE;
              load_q  <= 1'b1;
            end else begin
              state_q <= S_WAIT_HIGH;
              ferr_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_WAIT_HIGH;
      endcase
    end
  end

  assign pop = valid_q && ready;

  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    frame_err_d = ferr_q;
    if (load_q) begin
      data_d    = shift_q;
      valid_d   = 1'b1;
      // A simultaneous pop consumes the old byte, so nothing is lost.
      overrun_d = valid_q && !pop;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx with a short bit period so long frame sequences fit.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HLF  = CPB / 2;
  localparam int LAT  = 3 + HLF + 9 * CPB;  // edge of valid / frame_err
  localparam int STOPE = 2 + HLF + 9 * CPB; // edge of stop sample (busy falls)

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  int ev_valid, ev_ferr, ev_ovr, ev_brise, ev_bfall;

  uart_rx #(.CLKS_PER_BIT(CPB), .HALF(HLF)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Consumer-side observation: every accepted byte and every pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) got.push_back(data);
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a frame (start, 8 data LSB first, stop) and records, relative to
  // edge 0 (first edge that captures the start bit), when events occurred.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int nticks);
    logic [9:0] fr;
    logic vprev;
    fr = {stop_bit, b, 1'b0};
    ev_valid = -1; ev_ferr = -1; ev_ovr = -1; ev_brise = -1; ev_bfall = -1;
    vprev = valid;
    for (int i = 0; i < nticks; i++) begin
      if (i % CPB == 0) rx = fr[i / CPB];
      tick();
      if (ev_valid < 0 && valid && !vprev) ev_valid = i;
      if (ev_ferr < 0 && frame_err) ev_ferr = i;
      if (ev_ovr < 0 && overrun) ev_ovr = i;
      if (ev_brise < 0 && busy) ev_brise = i;
      if (ev_brise >= 0 && ev_bfall < 0 && !busy) ev_bfall = i;
      vprev = valid;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, (i < got.size()) ? {24'h0, got[i]} : 32'hxxxxxxxx, {24'h0, exp_q[i]});
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int f0, o0, busy_cnt, gap;
    logic [7:0] b;

    rst = 1'b1; rx = 1'b1; ready = 1'b1;
    repeat (3) tick();
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    idle(5);

    // Basic byte with timing of every event.
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'hAA, 1'b1, 10 * CPB);
    exp_q.push_back(8'hAA);
    chk("basic_valid_edge", ev_valid, LAT);
    chk("basic_busy_rise", ev_brise, 2);
    chk("basic_busy_fall", ev_bfall, STOPE);
    chk("basic_data", data, 8'hAA);
    chk("basic_no_ferr", ferr_cnt - f0, 0);
    chk("basic_no_ovr", ovr_cnt - o0, 0);
    cmp_q("basic_pop");

    // Back-to-back without gap.
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h00, 1'b1, 10 * CPB);
    exp_q.push_back(8'h00);
    send_frame(8'hFF, 1'b1, 10 * CPB);
    exp_q.push_back(8'hFF);
    chk("b2b_valid_edge", ev_valid, LAT);
    cmp_q("b2b_pop");
    for (int k = 0; k < 256; k++) begin
      send_frame(8'hAA, 1'b1, 10 * CPB);
      exp_q.push_back(8'hAA);
    end
    cmp_q("b2b_aa");
    chk("b2b_no_ferr", ferr_cnt - f0, 0);
    chk("b2b_no_ovr", ovr_cnt - o0, 0);

    // Glitch shorter than half a bit: busy for exactly HALF cycles, no byte.
    idle(5);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      rx = (i < 5) ? 1'b0 : 1'b1;
      tick();
      if (busy) busy_cnt++;
    end
    chk("glitch_busy_cycles", busy_cnt, HLF);
    chk("glitch_valid", valid, 1'b0);
    chk("glitch_busy_end", busy, 1'b0);
    cmp_q("glitch_pop");

    // Framing error, line held low, then a good byte.
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 10 * CPB);
    chk("ferr_edge", ev_ferr, LAT);
    chk("ferr_no_valid", ev_valid, -1);
    repeat (2 * CPB) tick();
    chk("ferr_busy_low_line", busy, 1'b0);
    idle(CPB);
    send_frame(8'h3C, 1'b1, 10 * CPB);
    exp_q.push_back(8'h3C);
    chk("ferr_count", ferr_cnt - f0, 1);
    cmp_q("ferr_pop");

    // Overrun: consumer stalled across two loads.
    idle(5);
    ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h12, 1'b1, 10 * CPB);
    send_frame(8'h34, 1'b1, 10 * CPB);
    chk("ovr_edge", ev_ovr, LAT);
    chk("ovr_count", ovr_cnt - o0, 1);
    chk("ovr_data", data, 8'h34);
    chk("ovr_valid", valid, 1'b1);
    ready = 1'b1;
    tick();
    chk("ovr_valid_fall", valid, 1'b0);
    exp_q.push_back(8'h34);
    cmp_q("ovr_pop");

    // Reset during bit 3 of 0xF0 while the line is low.
    idle(5);
    f0 = ferr_cnt;
    send_frame(8'hF0, 1'b1, 4 * CPB + HLF);
    rst = 1'b1;
    tick();
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (2) tick();
    idle(3 * CPB);
    chk("mid_rst_idle_busy", busy, 1'b0);
    cmp_q("mid_rst_no_byte");
    send_frame(8'hA5, 1'b1, 10 * CPB);
    exp_q.push_back(8'hA5);
    chk("mid_rst_next_edge", ev_valid, LAT);
    cmp_q("mid_rst_next");
    chk("mid_rst_no_ferr", ferr_cnt - f0, 0);

    // Randomised bytes with random idle gaps.
    f0 = ferr_cnt; o0 = ovr_cnt;
    for (int k = 0; k < 40; k++) begin
      b   = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 20);
      idle(gap);
      send_frame(b, 1'b1, 10 * CPB);
      exp_q.push_back(b);
    end
    cmp_q("rand_pop");
    chk("rand_no_ferr", ferr_cnt - f0, 0);
    chk("rand_no_ovr", ovr_cnt - o0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
